// File: rtl/ysyx_22050598_cache_tag_ctrl_pkg.sv
// Shared constants for the cache tag/valid controller: state encoding and address field layout.
package ysyx_22050598_cache_tag_ctrl_pkg;
    localparam int TAG_LSB        = 10;
    localparam int IDX_LSB        = 4;
    localparam int IDX_W          = 6;
    localparam int OFF_W          = 4;
    localparam int VALID_BIT      = 54;
    localparam int BEATS_PER_LINE = 2;
    localparam int INV_CNT_W      = 7;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_MREQ, S_MDATA, S_RESP, S_INV
    } state_e;
endpackage

// File: rtl/ysyx_22050598_cache_tag_ctrl_if.sv
// Bus bundle between the tag controller (master) and CPU port, tag/valid array, data array and refill bus.
interface ysyx_22050598_cache_tag_ctrl_if #(
    parameter int AW = 64,
    parameter int DW = 55,
    parameter int IW = 6
);
    logic          req_valid, req_ready, inv_req;
    logic [AW-1:0] req_addr;
    logic          resp_valid, resp_hit;
    logic          tv_wen;
    logic [IW-1:0] tv_set_index;
    logic [DW-1:0] tv_data_w, tv_data_r;
    logic          mem_req_valid, mem_req_ready, mem_rvalid;
    logic [AW-1:0] mem_req_addr;
    logic [63:0]   mem_rdata;
    logic          data_wen, data_beat;
    logic [63:0]   data_w;

    modport master (
        input  req_valid, req_addr, inv_req, tv_data_r, mem_req_ready, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_hit, tv_wen, tv_set_index, tv_data_w,
               mem_req_valid, mem_req_addr, data_wen, data_beat, data_w
    );
    modport slave (
        output req_valid, req_addr, inv_req, tv_data_r, mem_req_ready, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_hit, tv_wen, tv_set_index, tv_data_w,
               mem_req_valid, mem_req_addr, data_wen, data_beat, data_w
    );
endinterface

// File: rtl/ysyx_22050598_cache_tag_cmp.sv
// Combinational tag/valid entry compare; shared between I-cache and D-cache controllers.
module ysyx_22050598_cache_tag_cmp
    import ysyx_22050598_cache_tag_ctrl_pkg::*;
(
    input  logic [VALID_BIT:0]   entry_i,
    input  logic [VALID_BIT-1:0] tag_i,
    output logic                 hit_o
);
    assign hit_o = entry_i[VALID_BIT] & (entry_i[VALID_BIT-1:0] == tag_i);
endmodule

// File: rtl/ysyx_22050598_cache_tag_ctrl.sv
// Cache tag/valid controller: lookup, two-beat line refill and full invalidation sweep.
// Optional hit/miss counters when YSYX_22050598_CACHE_PERF_CNT_EN is defined.
module ysyx_22050598_cache_tag_ctrl
    import ysyx_22050598_cache_tag_ctrl_pkg::*;
#(
    parameter int AW = 64,
    parameter int DW = 55,
    parameter int DP = 64
) (
    input  logic clk,
    input  logic rst,
`ifdef YSYX_22050598_CACHE_PERF_CNT_EN
    output logic [63:0] perf_hit_cnt,
    output logic [63:0] perf_miss_cnt,
`endif
    ysyx_22050598_cache_tag_ctrl_if.master bus
);
    localparam int TW = AW - TAG_LSB;
    localparam int LW = AW - IDX_LSB;

    state_e                state_q;
    logic [LW-1:0]         line_q;
    logic                  beat_q;
    logic [INV_CNT_W-1:0]  inv_cnt_q;
    logic                  inv_pend_q;
    logic                  req_ready_q, resp_valid_q, resp_hit_q, mem_req_valid_q;

    logic [TW-1:0]    tag;
    logic [IDX_W-1:0] idx;
    logic [DW-1:0]    fill_entry;
    logic             hit, beat_fire, last_beat, inv_any, in_inv;
    logic             unused_off;

    assign tag        = line_q[LW-1:TAG_LSB-IDX_LSB];
    assign idx        = line_q[IDX_W-1:0];
    assign fill_entry = {1'b1, tag};
    assign beat_fire  = (state_q == S_MDATA) & bus.mem_rvalid;
    assign last_beat  = (beat_q == 1'(BEATS_PER_LINE - 1));
    assign inv_any    = bus.inv_req | inv_pend_q;
    assign in_inv     = (state_q == S_INV);
    assign unused_off = ^bus.req_addr[OFF_W-1:0];

    ysyx_22050598_cache_tag_cmp u_cmp (
        .entry_i (bus.tv_data_r),
        .tag_i   (tag),
        .hit_o   (hit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            line_q          <= '0;
            beat_q          <= 1'b0;
            inv_cnt_q       <= '0;
            inv_pend_q      <= 1'b0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_hit_q      <= 1'b0;
            mem_req_valid_q <= 1'b0;
        end else begin
            // Invalidations arriving while busy are remembered, not dropped
            if (bus.inv_req && state_q != S_IDLE) inv_pend_q <= 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    if (inv_any) begin
                        state_q     <= S_INV;
                        inv_pend_q  <= 1'b0;
                        inv_cnt_q   <= '0;
                        req_ready_q <= 1'b0;
                    end else if (bus.req_valid && req_ready_q) begin
                        state_q     <= S_LOOKUP;
                        line_q      <= bus.req_addr[AW-1:IDX_LSB];
                        req_ready_q <= 1'b0;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= 1'b1;
                    end else begin
                        state_q         <= S_MREQ;
                        mem_req_valid_q <= 1'b1;
                    end
                end
                S_MREQ: begin
                    if (bus.mem_req_ready) begin
                        state_q         <= S_MDATA;
                        mem_req_valid_q <= 1'b0;
                        beat_q          <= 1'b0;
                    end
                end
                S_MDATA: begin
                    if (beat_fire) begin
                        beat_q <= beat_q + 1'b1;
                        if (last_beat) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_hit_q   <= 1'b0;
                        end
                    end
                end
                S_RESP: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_hit_q   <= 1'b0;
                    // Hold off new requests so a pending sweep goes first
                    req_ready_q  <= ~(inv_pend_q | bus.inv_req);
                end
                S_INV: begin
                    if (inv_cnt_q == INV_CNT_W'(DP - 1)) begin
                        state_q     <= S_IDLE;
                        inv_cnt_q   <= '0;
                        req_ready_q <= ~(inv_pend_q | bus.inv_req);
                    end else begin
                        inv_cnt_q <= inv_cnt_q + 7'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_hit      = resp_hit_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = {line_q, {IDX_LSB{1'b0}}};
    assign bus.tv_wen        = in_inv | (beat_fire & last_beat);
    assign bus.tv_set_index  = in_inv ? inv_cnt_q[IDX_W-1:0] : idx;
    assign bus.tv_data_w     = (state_q == S_MDATA) ? fill_entry : '0;
    assign bus.data_wen      = beat_fire;
    assign bus.data_beat     = beat_fire & beat_q;
    assign bus.data_w        = beat_fire ? bus.mem_rdata : '0;

`ifdef YSYX_22050598_CACHE_PERF_CNT_EN
    logic [63:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (resp_valid_q) begin
            if (resp_hit_q) begin
                if (~&hit_cnt_q) hit_cnt_q <= hit_cnt_q + 64'd1;
            end else begin
                if (~&miss_cnt_q) miss_cnt_q <= miss_cnt_q + 64'd1;
            end
        end
    end

    assign perf_hit_cnt  = hit_cnt_q;
    assign perf_miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_ysyx_22050598_cache_tag_ctrl.sv
// Directed scoreboard bench for the cache tag controller: refill, hit, stall/gap, invalidate, mid-refill reset.
module tb_ysyx_22050598_cache_tag_ctrl;
    typedef struct packed { logic [5:0] idx; logic [54:0] data; } tv_exp_t;
    typedef struct packed { logic beat; logic [63:0] data; } dw_exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_22050598_cache_tag_ctrl_if bus();

`ifdef YSYX_22050598_CACHE_PERF_CNT_EN
    logic [63:0] perf_hit_cnt, perf_miss_cnt;
`endif

    ysyx_22050598_cache_tag_ctrl dut (
        .clk           (clk),
        .rst           (rst),
`ifdef YSYX_22050598_CACHE_PERF_CNT_EN
        .perf_hit_cnt  (perf_hit_cnt),
        .perf_miss_cnt (perf_miss_cnt),
`endif
        .bus           (bus)
    );

    // Tag/valid array model: combinational read, write on the clock edge
    logic [54:0] tv_arr [64] = '{default: '0};
    assign bus.tv_data_r = tv_arr[bus.tv_set_index];
    always @(posedge clk) if (bus.tv_wen === 1'b1) tv_arr[bus.tv_set_index] <= bus.tv_data_w;

    int n_tests = 0;
    int n_fail  = 0;
    logic    q_resp [$];
    tv_exp_t q_tv   [$];
    dw_exp_t q_dw   [$];
    logic [63:0] q_mreq [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon();
        tv_exp_t t;
        dw_exp_t d;
        if (bus.resp_valid === 1'b1) begin
            if (q_resp.size() == 0) chk("resp_unexpected", bus.resp_valid, 0);
            else chk("resp_hit", bus.resp_hit, q_resp.pop_front());
        end
        if (bus.tv_wen === 1'b1) begin
            if (q_tv.size() == 0) chk("tv_wen_unexpected", bus.tv_wen, 0);
            else begin
                t = q_tv.pop_front();
                chk("tv_idx", bus.tv_set_index, t.idx);
                chk("tv_data", bus.tv_data_w, t.data);
            end
        end
        if (bus.data_wen === 1'b1) begin
            if (q_dw.size() == 0) chk("data_wen_unexpected", bus.data_wen, 0);
            else begin
                d = q_dw.pop_front();
                chk("data_beat", bus.data_beat, d.beat);
                chk("data_w", bus.data_w, d.data);
            end
        end
        if (bus.mem_req_valid === 1'b1) begin
            if (q_mreq.size() == 0) chk("mreq_unexpected", bus.mem_req_valid, 0);
            else begin
                chk("mreq_addr", bus.mem_req_addr, q_mreq[0]);
                if (bus.mem_req_ready) void'(q_mreq.pop_front());
            end
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge
    task automatic cycle();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [63:0] a);
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 100) begin cycle(); n++; end
        chk("req_ready_timeout", n < 100, 1);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        cycle();
        bus.req_valid = 1'b0;
    endtask

    task automatic serve(input logic [63:0] a, input int stall, input int gap,
                         input logic [63:0] d0, input logic [63:0] d1, input bit inv_in_gap);
        int n = 0;
        q_mreq.push_back({a[63:4], 4'h0});
        while (bus.mem_req_valid !== 1'b1 && n < 20) begin cycle(); n++; end
        chk("mreq_timeout", n < 20, 1);
        repeat (stall) cycle();
        bus.mem_req_ready = 1'b1;
        cycle();
        bus.mem_req_ready = 1'b0;
        q_dw.push_back('{beat: 1'b0, data: d0});
        bus.mem_rvalid = 1'b1; bus.mem_rdata = d0;
        cycle();
        bus.mem_rvalid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            bus.inv_req = inv_in_gap && (i == 0);
            cycle();
            bus.inv_req = 1'b0;
        end
        q_dw.push_back('{beat: 1'b1, data: d1});
        q_tv.push_back('{idx: a[9:4], data: {1'b1, a[63:10]}});
        q_resp.push_back(1'b0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = d1;
        cycle();
        bus.mem_rvalid = 1'b0;
        chk("miss_resp_valid", bus.resp_valid, 1);
        cycle();
    endtask

    task automatic expect_hit(input logic [63:0] a);
        do_req(a);
        q_resp.push_back(1'b1);
        chk("lookup_no_resp", bus.resp_valid, 0);
        cycle();
        chk("hit_latency2", bus.resp_valid, 1);
        cycle();
    endtask

    initial begin
        int n;
        rst = 1'b0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.inv_req = 1'b0;
        bus.mem_req_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_tv_wen", bus.tv_wen, 0);
        chk("rst_mreq_valid", bus.mem_req_valid, 0);
        chk("rst_data_wen", bus.data_wen, 0);
        chk("rst_tv_idx", bus.tv_set_index, 0);
        chk("rst_mreq_addr", bus.mem_req_addr, 0);
        rst = 1'b1;
        cycle();

        // Cold miss: tag 0x200000 at index 1
        do_req(64'h8000_0010);
        chk("first_tv_expect", {1'b1, 54'h20_0000}, {1'b1, q_tv.size() == 0 ? 54'h20_0000 : 54'h0});
        serve(64'h8000_0010, 0, 0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0);
        chk("tv_arr_idx1", tv_arr[1], {1'b1, 54'h20_0000});
        expect_hit(64'h8000_0010);

        // Same index, different tag overwrites
        do_req(64'h9000_0010);
        serve(64'h9000_0010, 0, 0, 64'hA, 64'hB, 1'b0);
        chk("tv_arr_idx1_new", tv_arr[1], {1'b1, 54'h24_0000});

        // Boundary: index 63, all-ones tag; stalled handshake and gapped beats
        do_req(64'hFFFF_FFFF_FFFF_FFF8);
        serve(64'hFFFF_FFFF_FFFF_FFF8, 5, 3, 64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002, 1'b0);
        expect_hit(64'hFFFF_FFFF_FFFF_FFF8);

        // Invalidate pulse mid-refill: refill finishes, then full sweep
        do_req(64'h8000_0020);
        serve(64'h8000_0020, 0, 1, 64'h77, 64'h88, 1'b1);
        chk("inv_pending_blocks_req", bus.req_ready, 0);
        for (int i = 0; i < 64; i++) q_tv.push_back('{idx: 6'(i), data: 55'h0});
        n = 0;
        while (bus.tv_wen !== 1'b1 && n < 10) begin cycle(); n++; end
        chk("inv_start_timeout", n < 10, 1);
        for (int i = 0; i < 64; i++) begin
            chk("inv_tv_wen", bus.tv_wen, 1);
            cycle();
        end
        chk("inv_done_tv_wen", bus.tv_wen, 0);
        chk("inv_done_req_ready", bus.req_ready, 1);
        do_req(64'h8000_0010);
        serve(64'h8000_0010, 1, 0, 64'h99, 64'hAA, 1'b0);

        // Reset after the first refill beat abandons the line
        do_req(64'h8000_0030);
        q_mreq.push_back(64'h8000_0030);
        n = 0;
        while (bus.mem_req_valid !== 1'b1 && n < 20) begin cycle(); n++; end
        chk("abort_mreq_timeout", n < 20, 1);
        bus.mem_req_ready = 1'b1; cycle(); bus.mem_req_ready = 1'b0;
        q_dw.push_back('{beat: 1'b0, data: 64'h1234});
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h1234; cycle(); bus.mem_rvalid = 1'b0;
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        chk("abort_req_ready", bus.req_ready, 1);
        chk("abort_tv_wen", bus.tv_wen, 0);
        chk("abort_resp_valid", bus.resp_valid, 0);
        repeat (2) cycle();
        chk("abort_idx3_invalid", tv_arr[3], 0);
        do_req(64'h8000_0030);
        serve(64'h8000_0030, 0, 2, 64'h5678, 64'h9ABC, 1'b0);
        expect_hit(64'h8000_0030);

        repeat (2) cycle();
        chk("q_resp_drained", q_resp.size(), 0);
        chk("q_tv_drained", q_tv.size(), 0);
        chk("q_dw_drained", q_dw.size(), 0);
        chk("q_mreq_drained", q_mreq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
